pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter: WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter: CNT_W, default 8, width of the flush-drop statistics counter.
REQ-003 Parameter: ZERO_INVALID, default 1, when 1 out_data reads 0 whenever out_valid=0.
REQ-004 Port: Clk  input  1  sole clock, all state on rising edge.
REQ-005 Port: Rst  input  1  synchronous, active-high reset.
REQ-006 Port: in_valid  input  1  upstream payload valid.
REQ-007 Port: in_ready  output  1  stage can accept this cycle.
REQ-008 Port: in_data  input  WIDTH  upstream payload.
REQ-009 Port: out_valid  output  1  stage presents a valid payload.
REQ-010 Port: out_ready  input  1  downstream accepts this cycle.
REQ-011 Port: out_data  output  WIDTH  payload to downstream.
REQ-012 Port: stall  input  1  freeze: no accept, no emit, contents held.
REQ-013 Port: bubble  input  1  flush: discard all held entries.
REQ-014 Port: count  output  2  current occupancy, 0..2.
REQ-015 Port: drop_cnt  output  CNT_W  saturating count of entries discarded by bubble.

Function
REQ-016 Storage is two WIDTH-bit entries, main and skid; state EMPTY (0 held), ONE (main), TWO (main+skid); count SHALL equal 0/1/2 respectively.
REQ-017 Priority per cycle SHALL be Rst > stall > bubble > normal transfer; bubble asserted with stall has no effect.
REQ-018 in_ready SHALL be combinational: 1 iff state!=TWO and stall=0 and bubble=0.
REQ-019 out_valid SHALL be combinational: 1 iff state!=EMPTY and stall=0 and bubble=0.
REQ-020 out_data SHALL be main; when out_valid=0 and ZERO_INVALID=1 it SHALL be 0.
REQ-021 accept = in_valid & in_ready; emit = out_valid & out_ready; only these events move data.
REQ-022 EMPTY: accept -> ONE, main<=in_data; otherwise stay.
REQ-023 ONE: accept&!emit -> TWO, skid<=in_data; emit&!accept -> EMPTY; accept&emit -> ONE, main<=in_data; neither -> stay.
REQ-024 TWO: emit -> ONE, main<=skid; otherwise stay (accept impossible).
REQ-025 Latency in_data to out_data SHALL be exactly 1 cycle when empty; sustained throughput 1 per cycle with out_ready=1.
REQ-026 Ordering SHALL be strict FIFO; no payload duplicated or lost except by bubble.
REQ-027 stall=1: state, main, skid, count, drop_cnt SHALL hold; in_ready=out_valid=0.
REQ-028 bubble=1 (stall=0): next state EMPTY, main and skid <= 0, drop_cnt += count (pre-flush occupancy), saturating at 2^CNT_W-1.
REQ-029 Entry order within a cycle: flush discards both entries even if in_valid/out_ready are high; no transfer occurs that cycle.
REQ-030 drop_cnt SHALL never wrap; addition that would exceed max clamps to max.

Reset
REQ-031 Rst=1 at a rising edge: state EMPTY, main=skid=0, count=0, drop_cnt=0, regardless of stall/bubble.
REQ-032 While Rst=1, in_ready and out_valid SHALL read 0; out_data 0 when ZERO_INVALID=1.
REQ-033 Rst mid-operation (state TWO) SHALL discard entries without incrementing drop_cnt.
REQ-034 First cycle after Rst deasserts, in_ready=1 (if stall=bubble=0).

Verification
REQ-035 Streaming: out_ready=1, push 0x11,0x22,0x33 back-to-back -> out_data 0x11,0x22,0x33 on consecutive cycles each one cycle after input, count stays <=1.
REQ-036 Backpressure: out_ready=0, push 0xA1,0xA2 -> count=2, in_ready=0; third push 0xA3 held upstream; out_ready=1 -> 0xA1,0xA2,0xA3 in order, no loss.
REQ-037 Stall: state TWO, stall=1 for 3 cycles with in_valid=out_ready=1 -> out_valid=in_ready=0, count stays 2; release -> 0xA1 emitted first.
REQ-038 Flush: state TWO, bubble=1 -> next cycle count=0, out_valid=0, out_data=0, drop_cnt=2; bubble with stall=1 -> no change.
REQ-039 Saturation: CNT_W=2, flush two full stages -> drop_cnt=3 (not 0); Rst -> drop_cnt=0, count=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry (main + skid) pipeline register stage with stall, flush and a saturating flush-drop counter.
// Latency: in_data to out_data is one cycle when the stage is empty; it sustains one transfer per cycle.
// Backpressure: in_ready drops when both entries are full; stall freezes everything; bubble discards the contents.
module pipe_stage_reg #(
  parameter int WIDTH        = 32,
  parameter int CNT_W        = 8,
  parameter int ZERO_INVALID = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             bubble,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] drop_cnt
);

  // The state encoding equals the occupancy, so count is the state register itself.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W+1:0] DROP_MAX = {2'b00, {CNT_W{1'b1}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             active;
  logic             accept;
  logic             emit;
  logic [CNT_W+1:0] drop_sum;

  // Handshake outputs and transfer events; Rst, stall and bubble all close both ports.
  always_comb begin
    active    = !Rst && !stall && !bubble;
    in_ready  = active && (state_q != ST_TWO);
    out_valid = active && (state_q != ST_EMPTY);
    accept    = in_valid && in_ready;
    emit      = out_valid && out_ready;
    if ((ZERO_INVALID != 0) && !out_valid) begin
      out_data = '0;
    end else begin
      out_data = main_q;
    end
    count    = state_q;
    drop_cnt = drop_q;
  end

  // Saturating add of the pre-flush occupancy; two spare bits keep the sum from overflowing for any CNT_W.
  always_comb begin
    drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, state_q};
  end

  // Next-state logic: stall holds, bubble empties and counts drops, otherwise move data on accept/emit.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    drop_d  = drop_q;
    if (stall) begin
      state_d = state_q;
    end else if (bubble) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
      if (drop_sum > DROP_MAX) begin
        drop_d = {CNT_W{1'b1}};
      end else begin
        drop_d = drop_sum[CNT_W-1:0];
      end
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (accept && !emit) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (emit && !accept) begin
            state_d = ST_EMPTY;
          end else if (accept && emit) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so the only event is the skid entry moving up.
          if (emit) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; reset wins over stall and bubble and does not count discarded entries.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, stall, flush, saturation.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Uses CNT_W=2 so drop counter saturation is reachable with two flushes.
module tb_pipe_stage_reg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 2;

  logic             Clk;
  logic             Rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             stall;
  logic             bubble;
  logic [1:0]       count;
  logic [CNT_W-1:0] drop_cnt;

  int n_checks;
  int n_fail;

  pipe_stage_reg #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W),
    .ZERO_INVALID(1)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .stall(stall),
    .bubble(bubble),
    .count(count),
    .drop_cnt(drop_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push_two(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    tick();
    in_data   = b;
    tick();
    in_valid  = 1'b0;
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    Rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    bubble    = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    chk("rst_drop", drop_cnt, 0);
    Rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Streaming
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    chk("str_v1", out_valid, 1);
    chk("str_d1", out_data, 32'h11);
    chk("str_c1", count, 1);
    in_data = 32'h22;
    tick();
    chk("str_d2", out_data, 32'h22);
    chk("str_c2", count, 1);
    in_data = 32'h33;
    tick();
    chk("str_d3", out_data, 32'h33);
    chk("str_c3", count, 1);
    in_valid = 1'b0;
    tick();
    chk("str_empty_c", count, 0);
    chk("str_empty_v", out_valid, 0);
    chk("str_empty_d", out_data, 0);

    // Backpressure
    push_two(32'hA1, 32'hA2);
    chk("bp_count2", count, 2);
    in_valid = 1'b1;
    in_data  = 32'hA3;
    #1;
    chk("bp_in_ready", in_ready, 0);
    tick();
    chk("bp_hold_count", count, 2);
    chk("bp_d1", out_data, 32'hA1);
    out_ready = 1'b1;
    tick();
    chk("bp_d2", out_data, 32'hA2);
    chk("bp_c2", count, 1);
    tick();
    chk("bp_d3", out_data, 32'hA3);
    chk("bp_c3", count, 1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", count, 0);

    // Stall
    push_two(32'hA1, 32'hA2);
    stall     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hA3;
    out_ready = 1'b1;
    #1;
    chk("stl_out_valid", out_valid, 0);
    chk("stl_in_ready", in_ready, 0);
    chk("stl_out_data", out_data, 0);
    repeat (3) tick();
    chk("stl_count", count, 2);
    stall    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("stl_rel_v", out_valid, 1);
    chk("stl_rel_d", out_data, 32'hA1);
    tick();
    chk("stl_rel_d2", out_data, 32'hA2);
    tick();
    chk("stl_drain", count, 0);

    // Flush, first with stall (no effect), then alone
    push_two(32'hC1, 32'hC2);
    stall  = 1'b1;
    bubble = 1'b1;
    tick();
    chk("fl_stall_count", count, 2);
    chk("fl_stall_drop", drop_cnt, 0);
    stall     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("fl_in_ready", in_ready, 0);
    chk("fl_out_valid", out_valid, 0);
    tick();
    bubble    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("fl_count", count, 0);
    chk("fl_out_valid2", out_valid, 0);
    chk("fl_out_data", out_data, 0);
    chk("fl_drop", drop_cnt, 2);

    // Saturation: second full flush clamps at 3
    push_two(32'hD1, 32'hD2);
    bubble = 1'b1;
    tick();
    bubble = 1'b0;
    #1;
    chk("sat_drop", drop_cnt, 3);
    chk("sat_count", count, 0);

    // Reset from TWO discards without counting
    push_two(32'hE1, 32'hE2);
    chk("rst2_pre_count", count, 2);
    Rst    = 1'b1;
    bubble = 1'b1;
    #1;
    chk("rst2_in_ready", in_ready, 0);
    tick();
    chk("rst2_count", count, 0);
    chk("rst2_drop", drop_cnt, 0);
    Rst    = 1'b0;
    bubble = 1'b0;
    #1;
    chk("rst2_in_ready_after", in_ready, 1);
    tick();
    chk("rst2_drop_after", drop_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
